// File: rtl/cpu_output_monitor.sv
// cpu_output_monitor: tracks CPU run state, counts run cycles,
// captures OutReg changes into a FWFT FIFO, watchdog on Halt.
module cpu_output_monitor #(
  parameter int DataWidth = 16,
  parameter int FifoDepth = 8,
  parameter int CntWidth  = 16,
  parameter int Timeout   = 1000
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Ready,
  input  logic                         Halt,
  input  logic [DataWidth-1:0]         OutReg,
  input  logic                         Pop,
  output logic [DataWidth-1:0]         PopData,
  output logic                         PopValid,
  output logic [$clog2(FifoDepth):0]   Count,
  output logic                         Overflow,
  output logic [CntWidth-1:0]          CycleCount,
  output logic                         Running,
  output logic                         Halted,
  output logic                         TimedOut
);

  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
  localparam logic [CntWidth-1:0] ToLast = CntWidth'(Timeout - 1);
  localparam logic [CW-1:0] Full = CW'(FifoDepth);

  typedef enum logic [1:0] {
    S_Idle,
    S_Run,
    S_Halted,
    S_TimedOut
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cyc_q, cyc_d;
  logic [DataWidth-1:0]  last_q, last_d;
  logic                  push;

  logic [DataWidth-1:0]  mem_q [FifoDepth];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_q;
  logic                  run_q, halt_q, tout_q;

  logic                  pop_ok;
  logic                  push_ok;
  logic                  full;

  // Next state, cycle counter and capture decision
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    last_d  = last_q;
    push    = 1'b0;
    unique case (state_q)
      S_Idle: begin
        if (Ready) begin
          state_d = S_Run;
          cyc_d   = '0;
          last_d  = OutReg;
        end
      end
      S_Run: begin
        if (!Ready) begin
          state_d = S_Idle;
        end else begin
          if (cyc_q != '1)
            cyc_d = cyc_q + 1'b1;
          if (OutReg != last_q) begin
            push   = 1'b1;
            last_d = OutReg;
          end
          if (Halt)
            state_d = S_Halted;
          else if (Timeout != 0 && cyc_q == ToLast)
            state_d = S_TimedOut;
        end
      end
      S_Halted, S_TimedOut: begin
        if (!Ready)
          state_d = S_Idle;
      end
      default: state_d = S_Idle;
    endcase
  end

  // State, counter, baseline and registered status decodes
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_Idle;
      cyc_q   <= '0;
      last_q  <= '0;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      last_q  <= last_d;
      run_q   <= (state_d == S_Run);
      halt_q  <= (state_d == S_Halted);
      tout_q  <= (state_d == S_TimedOut);
    end
  end

  assign full    = (cnt_q == Full);
  assign pop_ok  = Pop && (cnt_q != '0);
  assign push_ok = push && (!full || pop_ok);

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok)
        wptr_q <= wptr_q + 1'b1;
      if (pop_ok)
        rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      if (push && !push_ok)
        ovf_q <= 1'b1;
    end
  end

  // FIFO storage; contents are masked while empty
  always_ff @(posedge Clk) begin
    if (push_ok)
      mem_q[wptr_q] <= OutReg;
  end

  assign PopValid   = (cnt_q != '0);
  assign PopData    = PopValid ? mem_q[rptr_q] : '0;
  assign Count      = cnt_q;
  assign Overflow   = ovf_q;
  assign CycleCount = cyc_q;
  assign Running    = run_q;
  assign Halted     = halt_q;
  assign TimedOut   = tout_q;

endmodule

// File: tb/tb_cpu_output_monitor.sv
// tb_cpu_output_monitor: directed vectors for the CPU
// output monitor (Timeout=20, FifoDepth=8).
module tb_cpu_output_monitor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Ready;
  logic        Halt;
  logic [15:0] OutReg;
  logic        Pop;
  logic [15:0] PopData;
  logic        PopValid;
  logic [3:0]  Count;
  logic        Overflow;
  logic [15:0] CycleCount;
  logic        Running;
  logic        Halted;
  logic        TimedOut;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_output_monitor #(
    .DataWidth(16),
    .FifoDepth(8),
    .CntWidth(16),
    .Timeout(20)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Ready(Ready),
    .Halt(Halt),
    .OutReg(OutReg),
    .Pop(Pop),
    .PopData(PopData),
    .PopValid(PopValid),
    .Count(Count),
    .Overflow(Overflow),
    .CycleCount(CycleCount),
    .Running(Running),
    .Halted(Halted),
    .TimedOut(TimedOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Ready = 1'b0;
    Halt = 1'b0;
    Pop = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".cnt"}, 32'(Count), 0);
    chk({tag, ".vld"}, 32'(PopValid), 0);
    chk({tag, ".dat"}, 32'(PopData), 0);
    chk({tag, ".ovf"}, 32'(Overflow), 0);
    chk({tag, ".cyc"}, 32'(CycleCount), 0);
    chk({tag, ".run"}, 32'(Running), 0);
    chk({tag, ".hlt"}, 32'(Halted), 0);
    chk({tag, ".tmo"}, 32'(TimedOut), 0);
  endtask

  initial begin
    Reset = 1'b0;
    Ready = 1'b0;
    Halt = 1'b0;
    Pop = 1'b0;
    OutReg = '0;
    step(2);
    Reset = 1'b1;
    step();
    chk_zero("rst");

    // basic capture then halt
    Ready = 1'b1;
    step();
    chk("t2.run", 32'(Running), 1);
    chk("t2.cyc0", 32'(CycleCount), 0);
    chk("t2.base", 32'(Count), 0);
    OutReg = 16'd5;
    step();
    chk("t2.cnt1", 32'(Count), 1);
    chk("t2.head", 32'(PopData), 5);
    step();
    chk("t2.same", 32'(Count), 1);
    OutReg = 16'd9;
    Halt = 1'b1;
    step();
    chk("t2.cnt2", 32'(Count), 2);
    chk("t2.hlt", 32'(Halted), 1);
    chk("t2.run0", 32'(Running), 0);
    chk("t2.cyc", 32'(CycleCount), 3);
    Halt = 1'b0;
    OutReg = 16'd7;
    step(2);
    chk("t2.frz", 32'(CycleCount), 3);
    chk("t2.nocap", 32'(Count), 2);
    Pop = 1'b1;
    chk("t2.pop5", 32'(PopData), 5);
    step();
    chk("t2.pop9", 32'(PopData), 9);
    step();
    Pop = 1'b0;
    chk("t2.empty", 32'(PopValid), 0);
    chk("t2.dat0", 32'(PopData), 0);

    // overflow
    do_reset();
    OutReg = 16'h0;
    Ready = 1'b1;
    step();
    for (int i = 1; i <= 10; i++) begin
      OutReg = 16'h100 + 16'(i);
      step();
    end
    chk("t3.cnt", 32'(Count), 8);
    chk("t3.ovf", 32'(Overflow), 1);
    chk("t3.head", 32'(PopData), 32'h101);
    Pop = 1'b1;
    OutReg = 16'h200;
    step();
    Pop = 1'b0;
    chk("t3.cntpp", 32'(Count), 8);
    chk("t3.head2", 32'(PopData), 32'h102);
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    Pop = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      chk("t3.drain", 32'(PopData), 32'h100 + 32'(i));
      step();
    end
    chk("t3.last", 32'(PopData), 32'h200);
    step();
    Pop = 1'b0;
    chk("t3.empty", 32'(PopValid), 0);
    chk("t3.sticky", 32'(Overflow), 1);

    // mid-run reset with three entries
    do_reset();
    chk("t1.ovf0", 32'(Overflow), 0);
    OutReg = 16'h0;
    Ready = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      OutReg = 16'(i);
      step();
    end
    chk("t1.cnt3", 32'(Count), 3);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    chk("t1.cnt0", 32'(Count), 0);
    chk("t1.run0", 32'(Running), 0);
    chk("t1.cyc0", 32'(CycleCount), 0);
    chk("t1.vld0", 32'(PopValid), 0);

    // watchdog
    do_reset();
    OutReg = 16'h0;
    Ready = 1'b1;
    step();
    step(19);
    chk("t4.pre", 32'(TimedOut), 0);
    chk("t4.cyc19", 32'(CycleCount), 19);
    step();
    chk("t4.tmo", 32'(TimedOut), 1);
    chk("t4.cyc20", 32'(CycleCount), 20);
    chk("t4.run0", 32'(Running), 0);
    step(3);
    chk("t4.frz", 32'(CycleCount), 20);
    chk("t4.hold", 32'(TimedOut), 1);

    // halt beats timeout
    do_reset();
    Ready = 1'b1;
    step();
    step(19);
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    chk("t4.hlt", 32'(Halted), 1);
    chk("t4.notmo", 32'(TimedOut), 0);
    chk("t4.hcyc", 32'(CycleCount), 20);

    // Ready drop retains FIFO, restart sets new baseline
    do_reset();
    OutReg = 16'h0;
    Ready = 1'b1;
    step();
    OutReg = 16'h1;
    step();
    OutReg = 16'h2;
    step();
    chk("t5.cnt2", 32'(Count), 2);
    Ready = 1'b0;
    step();
    chk("t5.idle", 32'(Running), 0);
    chk("t5.keep", 32'(Count), 2);
    OutReg = 16'h33;
    step();
    Ready = 1'b1;
    step();
    chk("t5.run", 32'(Running), 1);
    chk("t5.cyc0", 32'(CycleCount), 0);
    chk("t5.nobase", 32'(Count), 2);
    step();
    chk("t5.cyc1", 32'(CycleCount), 1);
    chk("t5.still", 32'(Count), 2);

    // pop on empty while pushing
    do_reset();
    OutReg = 16'h0;
    Ready = 1'b1;
    step();
    Pop = 1'b1;
    OutReg = 16'h44;
    step();
    Pop = 1'b0;
    chk("t6.cnt", 32'(Count), 1);
    chk("t6.dat", 32'(PopData), 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
